// File: rtl/and_reduce_pkg.sv
// Shared mode encodings and bit-level helpers for the reduction pipeline.
`default_nettype none

package and_reduce_pkg;

  typedef enum logic [1:0] {
    MODE_AND  = 2'b00,
    MODE_OR   = 2'b01,
    MODE_XOR  = 2'b10,
    MODE_XNOR = 2'b11
  } mode_t;

  function automatic logic identity_bit(input mode_t mode);
    return (mode == MODE_AND);
  endfunction

  // XNOR combines as XOR; the single inversion happens at the pipe output.
  function automatic logic combine(input logic a, input logic b, input mode_t mode);
    logic r;
    if (mode == MODE_AND)
      r = a & b;
    else if (mode == MODE_OR)
      r = a | b;
    else
      r = a ^ b;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/and_reduce_pipe_if.sv
// Valid/ready bus of the reduction pipeline: operand side and result side.
`default_nettype none

interface and_reduce_pipe_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] in_mask;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic             out_data;
  logic             out_empty;

  modport master (
    output in_valid, in_data, in_mask, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_empty
  );

  modport slave (
    input  in_valid, in_data, in_mask, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_empty
  );

endinterface

`default_nettype wire

// File: rtl/reduce_stage.sv
// One registered tree level: folds IN_W bits into IN_W/2 and carries valid/mode/empty.
`default_nettype none

module reduce_stage
  import and_reduce_pkg::*;
#(
  parameter int IN_W = 2
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              en,
  input  wire logic              in_valid,
  input  wire logic [IN_W-1:0]   in_bits,
  input  wire mode_t             in_mode,
  input  wire logic              in_empty,
  output logic                   out_valid,
  output logic [IN_W/2-1:0]      out_bits,
  output mode_t                  out_mode,
  output logic                   out_empty
);

  logic [IN_W/2-1:0] pair_bits;

  for (genvar j = 0; j < IN_W / 2; j++) begin : g_pair
    assign pair_bits[j] = combine(in_bits[2*j], in_bits[2*j+1], in_mode);
  end

  // Payload only loads on a real transaction so bubbles leave the last result in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_bits  <= '0;
      out_mode  <= MODE_AND;
      out_empty <= 1'b0;
    end else if (en) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_bits  <= pair_bits;
        out_mode  <= in_mode;
        out_empty <= in_empty;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/and_reduce_pipe.sv
// N-bit masked AND/OR/XOR/XNOR reduction with a registered binary tree and global-stall handshake.
`default_nettype none

module and_reduce_pipe
  import and_reduce_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LEVELS = $clog2(WIDTH)
) (
  input  wire logic        clk,
  input  wire logic        reset,
  and_reduce_pipe_if.slave bus
);

  localparam int PAD_W  = 1 << LEVELS;
  localparam int TREE_W = 2 * PAD_W - 1;

  // All tree levels packed end to end: level l is PAD_W>>l bits wide.
  logic [TREE_W-1:0] tree_bits;
  logic [LEVELS:0]   tree_valid;
  logic [LEVELS:0]   tree_empty;
  mode_t             tree_mode [0:LEVELS];

  logic  advance;
  mode_t in_mode_w;
  logic  ident;

  assign in_mode_w = mode_t'(bus.in_mode);
  assign ident     = identity_bit(in_mode_w);
  assign advance   = !tree_valid[LEVELS] || bus.out_ready;

  assign tree_valid[0] = bus.in_valid;
  assign tree_empty[0] = ~|bus.in_mask;
  assign tree_mode[0]  = in_mode_w;

  for (genvar i = 0; i < PAD_W; i++) begin : g_pad
    if (i < WIDTH) begin : g_live
      assign tree_bits[i] = bus.in_mask[i] ? bus.in_data[i] : ident;
    end else begin : g_fill
      assign tree_bits[i] = ident;
    end
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    localparam int IN_W    = PAD_W >> l;
    localparam int IN_OFF  = 2 * PAD_W - 2 * IN_W;
    localparam int OUT_OFF = 2 * PAD_W - IN_W;

    reduce_stage #(
      .IN_W (IN_W)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .en        (advance),
      .in_valid  (tree_valid[l]),
      .in_bits   (tree_bits[IN_OFF +: IN_W]),
      .in_mode   (tree_mode[l]),
      .in_empty  (tree_empty[l]),
      .out_valid (tree_valid[l+1]),
      .out_bits  (tree_bits[OUT_OFF +: IN_W/2]),
      .out_mode  (tree_mode[l+1]),
      .out_empty (tree_empty[l+1])
    );
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = tree_valid[LEVELS];
  assign bus.out_data  = tree_bits[TREE_W-1] ^ (tree_mode[LEVELS] == MODE_XNOR);
  assign bus.out_empty = tree_empty[LEVELS];

endmodule

`default_nettype wire

// File: tb/tb_and_reduce_pipe.sv
// Directed bench for and_reduce_pipe at WIDTH=8 (with result scoreboard) and WIDTH=5 (padding).
`default_nettype none

module tb_and_reduce_pipe;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  and_reduce_pipe_if #(.WIDTH(8)) b8 ();
  and_reduce_pipe_if #(.WIDTH(5)) b5 ();

  and_reduce_pipe #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(b8.slave));
  and_reduce_pipe #(.WIDTH(5)) dut5 (.clk(clk), .reset(reset), .bus(b5.slave));

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int out_count = 0;
  logic lat_chk = 1'b1;
  logic exp_d = 1'b0;
  logic exp_e = 1'b0;

  typedef struct {
    logic d;
    logic e;
    int   cyc;
  } exp_t;
  exp_t q[$];

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic [1:0] m, input logic [7:0] d, input logic [7:0] mk,
                        input logic ed, input logic ee);
    b8.in_valid = 1'b1;
    b8.in_mode  = m;
    b8.in_data  = d;
    b8.in_mask  = mk;
    exp_d = ed;
    exp_e = ee;
  endtask

  task automatic drive5(input logic [1:0] m, input logic [4:0] d, input logic [4:0] mk);
    b5.in_valid = 1'b1;
    b5.in_mode  = m;
    b5.in_data  = d;
    b5.in_mask  = mk;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard for the WIDTH=8 instance: expected values are captured at accept time.
  always @(negedge clk) begin
    if (!reset) begin
      if (b8.in_valid && b8.in_ready)
        q.push_back('{exp_d, exp_e, cyc});
      if (b8.out_valid && b8.out_ready) begin
        out_count++;
        if (q.size() == 0) begin
          check("w8_spurious_output", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("w8_out_data", int'(b8.out_data), int'(e.d));
          check("w8_out_empty", int'(b8.out_empty), int'(e.e));
          if (lat_chk)
            check("w8_latency", cyc - e.cyc, 3);
        end
      end
    end
  end

  initial begin
    b8.in_valid = 1'b0; b8.in_data = '0; b8.in_mask = '0; b8.in_mode = 2'b00; b8.out_ready = 1'b1;
    b5.in_valid = 1'b0; b5.in_data = '0; b5.in_mask = '0; b5.in_mode = 2'b00; b5.out_ready = 1'b1;

    // Reset state
    tick(); tick();
    check("rst_out_valid", int'(b8.out_valid), 0);
    check("rst_out_data", int'(b8.out_data), 0);
    check("rst_out_empty", int'(b8.out_empty), 0);
    reset = 1'b0;
    tick();
    check("in_ready_after_reset", int'(b8.in_ready), 1);

    // Walking fill, AND, full mask: only FF reduces to 1
    for (int i = 0; i <= 8; i++) begin
      logic [8:0] fill;
      fill = (9'd1 << i) - 9'd1;
      drive8(2'b00, fill[7:0], 8'hFF, (i == 8), 1'b0);
      tick();
    end

    // Mode coverage and masking, with a bubble in the middle
    drive8(2'b01, 8'h00, 8'hFF, 1'b0, 1'b0); tick();
    drive8(2'b01, 8'h80, 8'hFF, 1'b1, 1'b0); tick();
    drive8(2'b10, 8'hB5, 8'hFF, 1'b1, 1'b0); tick();
    b8.in_valid = 1'b0; b8.in_data = 8'h5A; tick();
    drive8(2'b11, 8'hB5, 8'hFF, 1'b0, 1'b0); tick();
    drive8(2'b00, 8'h0F, 8'h0F, 1'b1, 1'b0); tick();
    drive8(2'b00, 8'h00, 8'h00, 1'b1, 1'b1); tick();
    drive8(2'b10, 8'hFF, 8'h00, 1'b0, 1'b1); tick();
    drive8(2'b11, 8'h00, 8'h00, 1'b1, 1'b1); tick();
    b8.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("drain_1_queue", q.size(), 0);
    check("drain_1_count", out_count, 17);

    // Backpressure: out_ready low from the start, so the stall begins when the first result lands
    lat_chk = 1'b0;
    b8.out_ready = 1'b0;
    drive8(2'b00, 8'hFF, 8'hFF, 1'b1, 1'b0); tick();
    drive8(2'b00, 8'h00, 8'hFF, 1'b0, 1'b0); tick();
    drive8(2'b01, 8'h01, 8'hFF, 1'b1, 1'b0); tick();
    drive8(2'b10, 8'h03, 8'hFF, 1'b0, 1'b0);
    for (int s = 0; s < 4; s++) begin
      check("stall_in_ready", int'(b8.in_ready), 0);
      check("stall_out_valid", int'(b8.out_valid), 1);
      check("stall_out_data", int'(b8.out_data), 1);
      tick();
    end
    b8.out_ready = 1'b1;
    tick();
    drive8(2'b11, 8'h07, 8'hFF, 1'b0, 1'b0); tick();
    drive8(2'b00, 8'h0F, 8'h0F, 1'b1, 1'b0); tick();
    b8.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("drain_2_queue", q.size(), 0);
    check("drain_2_count", out_count, 23);
    lat_chk = 1'b1;

    // Reset with two transactions in flight
    drive8(2'b00, 8'hFF, 8'hFF, 1'b1, 1'b0); tick();
    drive8(2'b01, 8'hFF, 8'hFF, 1'b1, 1'b0); tick();
    b8.in_valid = 1'b0;
    reset = 1'b1;
    q.delete();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("post_reset_out_valid", int'(b8.out_valid), 0);
      tick();
    end
    check("post_reset_count", out_count, 23);
    drive8(2'b10, 8'h01, 8'hFF, 1'b1, 1'b0); tick();
    b8.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("drain_3_queue", q.size(), 0);
    check("drain_3_count", out_count, 24);

    // WIDTH=5 padding: identity fill must not disturb AND/XOR/OR results
    drive5(2'b00, 5'h1F, 5'h1F); tick();
    drive5(2'b10, 5'h1F, 5'h1F); tick();
    drive5(2'b01, 5'h00, 5'h1F);
    check("w5_not_early", int'(b5.out_valid), 0);
    tick();
    b5.in_valid = 1'b0;
    check("w5_and_valid", int'(b5.out_valid), 1);
    check("w5_and_data", int'(b5.out_data), 1);
    tick();
    check("w5_xor_valid", int'(b5.out_valid), 1);
    check("w5_xor_data", int'(b5.out_data), 1);
    tick();
    check("w5_or_valid", int'(b5.out_valid), 1);
    check("w5_or_data", int'(b5.out_data), 0);
    tick();
    check("w5_idle_valid", int'(b5.out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
